// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode/issue stage feeding the execute-stage ALU
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_op;
  logic        dec_illegal;
  logic        dec_alt;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             rd_we_q, rd_we_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic accept;
  logic handshake;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_q && out_ready;

  // Decode the incoming word into operands and opcode; unsupported encodings collapse to zeros.
  always_comb begin
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    dec_alt     = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        if (funct7 == F7_ZERO) begin
          dec_alt = 1'b0;
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_alt = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec_a = rs1_data;
        dec_b = {{20{instr[31]}}, instr[31:20]};
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift-immediates carry the shamt in rs2's field; the upper bits select SRAI only.
          dec_b = {27'd0, instr[24:20]};
          if (funct7 == F7_ALT && funct3 == 3'b101) begin
            dec_alt = 1'b1;
          end else if (funct7 != F7_ZERO) begin
            dec_illegal = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        dec_a = 32'd0;
        dec_b = {instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = {instr[31:12], 12'd0};
      end
      default: dec_illegal = 1'b1;
    endcase

    if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
      case (funct3)
        3'b000:  dec_op = dec_alt ? OP_SUB : OP_ADD;
        3'b001:  dec_op = OP_SLL;
        3'b010:  dec_op = OP_SLT;
        3'b011:  dec_op = OP_SLTU;
        3'b100:  dec_op = OP_XOR;
        3'b101:  dec_op = dec_alt ? OP_SRA : OP_SRL;
        3'b110:  dec_op = OP_OR;
        default: dec_op = OP_AND;
      endcase
    end

    if (dec_illegal) begin
      dec_a  = 32'd0;
      dec_b  = 32'd0;
      dec_op = OP_ADD;
    end
  end

  // Output slot next state: flush beats accept, accept beats drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rd_addr_d   = rd_addr_q;
    rd_we_d     = rd_we_q;
    illegal_d   = illegal_q;
    count_d     = handshake ? count_q + 1'b1 : count_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_a_d     = dec_a;
      alu_b_d     = dec_b;
      alu_op_d    = dec_op;
      rd_addr_d   = instr[11:7];
      rd_we_d     = !dec_illegal && (instr[11:7] != 5'd0);
      illegal_d   = dec_illegal;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  // Register the output slot and issue counter; reset also drops a stalled beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_op_q    <= 4'd0;
      rd_addr_q   <= 5'd0;
      rd_we_q     <= 1'b0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rd_addr_q   <= rd_addr_d;
      rd_we_q     <= rd_we_d;
      illegal_q   <= illegal_d;
      count_q     <= count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rd_addr     = rd_addr_q;
  assign rd_we       = rd_we_q;
  assign illegal     = illegal_q;
  assign issue_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      pc;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_op;
  logic [4:0]       rd_addr;
  logic             rd_we;
  logic             illegal;
  logic [CNT_W-1:0] issue_count;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [4:0] rd, input logic we,
                            input logic ill, input logic [CNT_W-1:0] cnt);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".a"}, alu_a, a);
    check({tag, ".b"}, alu_b, b);
    check({tag, ".op"}, {28'd0, alu_op}, {28'd0, op});
    check({tag, ".rd"}, {27'd0, rd_addr}, {27'd0, rd});
    check({tag, ".we"}, {31'd0, rd_we}, {31'd0, we});
    check({tag, ".ill"}, {31'd0, illegal}, {31'd0, ill});
    check({tag, ".cnt"}, {28'd0, issue_count}, {28'd0, cnt});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".a"}, alu_a, 32'd0);
    check({tag, ".b"}, alu_b, 32'd0);
    check({tag, ".op"}, {28'd0, alu_op}, 32'd0);
    check({tag, ".rd"}, {27'd0, rd_addr}, 32'd0);
    check({tag, ".we"}, {31'd0, rd_we}, 32'd0);
    check({tag, ".ill"}, {31'd0, illegal}, 32'd0);
    check({tag, ".cnt"}, {28'd0, issue_count}, 32'd0);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 32'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_zero("reset");

    // ADDI x1,x0,-1
    in_valid = 1'b1; instr = 32'hFFF00093; rs1_data = 32'd0;
    #1;
    check("addi.rs1_addr", {27'd0, rs1_addr}, 32'd0);
    tick();
    check_beat("addi", 32'd0, 32'hFFFFFFFF, 4'd0, 5'd1, 1'b1, 1'b0, 4'd0);

    // SUB x3,x1,x2
    instr = 32'h402081B3; rs1_data = 32'd10; rs2_data = 32'd3;
    #1;
    check("sub.rs2_addr", {27'd0, rs2_addr}, 32'd2);
    tick();
    check_beat("sub", 32'd10, 32'd3, 4'd1, 5'd3, 1'b1, 1'b0, 4'd1);

    // funct7 = 0x7F -> illegal
    instr = 32'hFE2081B3;
    tick();
    check_beat("bad_f7", 32'd0, 32'd0, 4'd0, 5'd3, 1'b0, 1'b1, 4'd2);

    // SRAI x5,x6,4
    instr = 32'h40435293; rs1_data = 32'h80;
    tick();
    check_beat("srai", 32'h80, 32'd4, 4'd7, 5'd5, 1'b1, 1'b0, 4'd3);

    // LUI x7,0x12345
    instr = 32'h123453B7;
    tick();
    check_beat("lui", 32'd0, 32'h12345000, 4'd0, 5'd7, 1'b1, 1'b0, 4'd4);

    // AUIPC x8,0x1 at pc 0x100
    instr = 32'h00001417; pc = 32'h100;
    tick();
    check_beat("auipc", 32'h100, 32'h1000, 4'd0, 5'd8, 1'b1, 1'b0, 4'd5);

    // ADD x0,x1,x2 -> legal, no write
    instr = 32'h00208033; rs1_data = 32'd5; rs2_data = 32'd6;
    tick();
    check_beat("add_x0", 32'd5, 32'd6, 4'd0, 5'd0, 1'b0, 1'b0, 4'd6);

    // Backpressure with a waiting XORI x9,x1,0xF0
    out_ready = 1'b0; instr = 32'h0F00C493; rs1_data = 32'hFF;
    #1;
    check("bp.in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_beat("bp_hold", 32'd5, 32'd6, 4'd0, 5'd0, 1'b0, 1'b0, 4'd6);
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_beat("xori", 32'hFF, 32'hF0, 4'd4, 5'd9, 1'b1, 1'b0, 4'd7);
    // OR x10,x1,x2
    instr = 32'h0020E533; rs1_data = 32'hF0; rs2_data = 32'h0F;
    tick();
    check_beat("or", 32'hF0, 32'h0F, 4'd3, 5'd10, 1'b1, 1'b0, 4'd8);
    // SLTU x11,x1,x2
    instr = 32'h0020B5B3; rs1_data = 32'd1; rs2_data = 32'd2;
    tick();
    check_beat("sltu", 32'd1, 32'd2, 4'd9, 5'd11, 1'b1, 1'b0, 4'd9);

    // Stall the SLTU beat
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check_beat("stall", 32'd1, 32'd2, 4'd9, 5'd11, 1'b1, 1'b0, 4'd9);

    // Flush with a completing handshake and an accepted beat that must be dropped
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instr = 32'hFFF00093; rs1_data = 32'd0;
    #1;
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    check("flush.cnt", {28'd0, issue_count}, 32'd9 + 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("post_flush.valid", {31'd0, out_valid}, 32'd0);
    check("post_flush.cnt", {28'd0, issue_count}, 32'd10);

    // Reset in the middle of a stall
    in_valid = 1'b1; out_ready = 1'b0; instr = 32'h123453B7;
    tick();
    check("pre_rst.valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_zero("mid_rst");

    // Counter wrap at CNT_W=4: sixteen back-to-back beats
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00208033;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("wrap.valid", {31'd0, out_valid}, 32'd1);
    end
    check("wrap.cnt15", {28'd0, issue_count}, 32'd15);
    in_valid = 1'b0;
    tick();
    check("wrap.cnt0", {28'd0, issue_count}, 32'd0);
    check("wrap.drained", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
